// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/branch controller:
// FSM state encoding, register-index width and source-valid bit positions.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int unsigned REG_W    = 3;
    localparam int unsigned NUM_REGS = 1 << REG_W;
    localparam int unsigned NUM_SRC  = 4;

    // Bit positions within src_vld and within the packed source-register bus
    localparam int unsigned VLD_RM = 0;
    localparam int unsigned VLD_RD = 1;
    localparam int unsigned VLD_SM = 2;
    localparam int unsigned VLD_SN = 3;

endpackage

// File: rtl/pipeline_ctrl_scoreboard.sv
// Load scoreboard: one 2-bit busy countdown per register plus the
// combinational load-use hazard compare against the IF/ID sources.
module load_scoreboard
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_issue,
    input  logic [REG_W-1:0]           ld_rd,
    input  logic [NUM_SRC*REG_W-1:0]   src_regs,
    input  logic [NUM_SRC-1:0]         src_vld,
    output logic                       hazard
);

    localparam logic [1:0] LAT = 2'(LOAD_LAT);

    logic [1:0] cnt_q [NUM_REGS];
    logic [1:0] cnt_d [NUM_REGS];

    // A fresh load overrides the decrement, which also restarts a busy register
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 2'd1 : '0;
        end
        if (ld_issue) begin
            cnt_d[ld_rd] = LAT;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (src_vld[s] && (cnt_q[src_regs[s*REG_W +: REG_W]] != '0)) begin
                hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: load-use stall and taken-branch flush sequencing with
// combinational PC/IF-ID/ID-EX controls and a saturating stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT   = 2,
    parameter int unsigned BR_PENALTY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_issue,
    input  logic [REG_W-1:0]   ld_rd,
    input  logic [REG_W-1:0]   src_rm,
    input  logic [REG_W-1:0]   src_rd,
    input  logic [REG_W-1:0]   src_sm,
    input  logic [REG_W-1:0]   src_sn,
    input  logic [NUM_SRC-1:0] src_vld,
    input  logic               br_taken,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ctrl_mux,
    output logic               ifid_flush,
    output logic [15:0]        stall_cnt
);

    localparam logic [1:0] PEN_LOAD = 2'(BR_PENALTY - 1);

    state_e                   state_q, state_d;
    logic [1:0]               pen_q, pen_d;
    logic [15:0]              stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC*REG_W-1:0] src_regs;
    logic                     hazard;

    always_comb begin
        src_regs = '0;
        src_regs[VLD_RM*REG_W +: REG_W] = src_rm;
        src_regs[VLD_RD*REG_W +: REG_W] = src_rd;
        src_regs[VLD_SM*REG_W +: REG_W] = src_sm;
        src_regs[VLD_SN*REG_W +: REG_W] = src_sn;
    end

    load_scoreboard #(
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_issue (ld_issue),
        .ld_rd    (ld_rd),
        .src_regs (src_regs),
        .src_vld  (src_vld),
        .hazard   (hazard)
    );

    always_comb begin
        state_d     = state_q;
        pen_d       = pen_q;
        stall_cnt_d = stall_cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ctrl_mux    = 1'b1;
        ifid_flush  = 1'b0;

        // Branch beats hazard; hazard is ignored while flushing
        if (br_taken || (state_q == ST_FLUSH)) begin
            ifid_flush = 1'b1;
            ctrl_mux   = 1'b0;
        end else if (hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_mux   = 1'b0;
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_FLUSH: begin
                if (br_taken) begin
                    pen_d = PEN_LOAD;
                end else if (pen_q <= 2'd1) begin
                    pen_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    pen_d = pen_q - 2'd1;
                end
            end
            default: begin
                if (br_taken) begin
                    if (BR_PENALTY > 1) begin
                        state_d = ST_FLUSH;
                        pen_d   = PEN_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (hazard) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pen_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pen_q       <= pen_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared against a per-register busy-cycle reference model.
module tb_pipeline_ctrl;

    localparam int LOAD_LAT   = 2;
    localparam int BR_PENALTY = 2;

    localparam logic [3:0] O_RUN   = 4'b1110;  // {pc_write, ifid_write, ctrl_mux, ifid_flush}
    localparam logic [3:0] O_STALL = 4'b0000;
    localparam logic [3:0] O_FLUSH = 4'b1101;

    logic        clk, rst_n;
    logic        ld_issue, br_taken;
    logic [2:0]  ld_rd, src_rm, src_rd, src_sm, src_sn;
    logic [3:0]  src_vld;
    logic        pc_write, ifid_write, ctrl_mux, ifid_flush;
    logic [15:0] stall_cnt;
    logic [3:0]  dut_out;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining busy cycles per register, remaining flush cycles
    int m_busy [8];
    int m_flush;
    int m_stall;

    pipeline_ctrl #(
        .LOAD_LAT   (LOAD_LAT),
        .BR_PENALTY (BR_PENALTY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_issue   (ld_issue),
        .ld_rd      (ld_rd),
        .src_rm     (src_rm),
        .src_rd     (src_rd),
        .src_sm     (src_sm),
        .src_sn     (src_sn),
        .src_vld    (src_vld),
        .br_taken   (br_taken),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .ctrl_mux   (ctrl_mux),
        .ifid_flush (ifid_flush),
        .stall_cnt  (stall_cnt)
    );

    assign dut_out = {pc_write, ifid_write, ctrl_mux, ifid_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_hazard();
        bit h = 0;
        if (src_vld[0] && m_busy[src_rm] > 0) h = 1;
        if (src_vld[1] && m_busy[src_rd] > 0) h = 1;
        if (src_vld[2] && m_busy[src_sm] > 0) h = 1;
        if (src_vld[3] && m_busy[src_sn] > 0) h = 1;
        return h;
    endfunction

    function automatic logic [3:0] m_expect();
        if (br_taken || m_flush > 0) return O_FLUSH;
        if (m_hazard()) return O_STALL;
        return O_RUN;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_busy[r] = 0;
        m_flush = 0;
        m_stall = 0;
    endtask

    // Advance one clock: model sees the same pre-edge inputs as the DUT
    task automatic model_clock();
        bit stall_now;
        bit br_now;
        bit ld_now;
        int rd_now;
        stall_now = !br_taken && m_flush == 0 && m_hazard();
        br_now    = br_taken;
        ld_now    = ld_issue;
        rd_now    = int'(ld_rd);
        @(posedge clk);
        if (stall_now && m_stall < 65535) m_stall++;
        for (int r = 0; r < 8; r++) if (m_busy[r] > 0) m_busy[r]--;
        if (ld_now) m_busy[rd_now] = LOAD_LAT;
        if (br_now) m_flush = BR_PENALTY - 1;
        else if (m_flush > 0) m_flush--;
        #1;
    endtask

    task automatic set_in(input bit ld, input int rd, input int rm, input int rdd,
                          input int sm, input int sn, input logic [3:0] vld, input bit br);
        ld_issue = ld;
        ld_rd    = 3'(rd);
        src_rm   = 3'(rm);
        src_rd   = 3'(rdd);
        src_sm   = 3'(sm);
        src_sn   = 3'(sn);
        src_vld  = vld;
        br_taken = br;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 4'b0000, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 4'b1111, 0);
        #3;
        total++;
        if (dut_out !== O_RUN) begin
            bad++;
            $display("FAIL reset_outputs: got %b want %b", dut_out, O_RUN);
        end
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        int stalls = 0;
        do_reset();
        set_in(1, 3, 0, 0, 0, 0, 4'b0000, 0);
        model_clock();
        set_in(0, 0, 3, 0, 0, 0, 4'b0001, 0);
        for (int c = 0; c < 4; c++) begin
            #2;
            total++;
            if (dut_out !== m_expect()) begin
                bad++;
                $display("FAIL load_use_c%0d: got %b want %b", c, dut_out, m_expect());
            end
            if (pc_write === 1'b0 && ctrl_mux === 1'b0) stalls++;
            model_clock();
        end
        total++;
        if (stalls != 2) begin
            bad++;
            $display("FAIL load_use_stall_cycles: got %0d want 2", stalls);
        end
        total++;
        if (stall_cnt !== 16'd2) begin
            bad++;
            $display("FAIL load_use_stall_cnt: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_invalid_src();
        do_reset();
        set_in(1, 3, 0, 0, 0, 0, 4'b0000, 0);
        model_clock();
        set_in(0, 0, 3, 3, 3, 3, 4'b0000, 0);
        for (int c = 0; c < 3; c++) begin
            #2;
            total++;
            if (dut_out !== O_RUN) begin
                bad++;
                $display("FAIL invalid_src_c%0d: got %b want %b", c, dut_out, O_RUN);
            end
            model_clock();
        end
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL invalid_src_stall_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_branch_in_stall();
        logic [3:0] want [3];
        want[0] = O_FLUSH;
        want[1] = O_FLUSH;
        want[2] = O_RUN;
        do_reset();
        set_in(1, 3, 0, 0, 0, 0, 4'b0000, 0);
        model_clock();
        set_in(0, 0, 3, 0, 0, 0, 4'b0001, 0);
        #2;
        total++;
        if (dut_out !== O_STALL) begin
            bad++;
            $display("FAIL br_stall_pre: got %b want %b", dut_out, O_STALL);
        end
        br_taken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (dut_out !== want[c]) begin
                bad++;
                $display("FAIL br_stall_c%0d: got %b want %b", c, dut_out, want[c]);
            end
            model_clock();
            br_taken = 1'b0;
        end
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL br_stall_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] want [5];
        want[0] = O_RUN;
        want[1] = O_STALL;
        want[2] = O_STALL;
        want[3] = O_STALL;
        want[4] = O_RUN;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_in(c < 2, 5, 0, 0, 0, 5, (c >= 1) ? 4'b1000 : 4'b0000, 0);
            #2;
            total++;
            if (dut_out !== want[c]) begin
                bad++;
                $display("FAIL back_to_back_c%0d: got %b want %b", c, dut_out, want[c]);
            end
            model_clock();
        end
        total++;
        if (stall_cnt !== 16'd3) begin
            bad++;
            $display("FAIL back_to_back_stall_cnt: got %0d want 3", stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] e;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            set_in($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   4'($urandom), $urandom_range(0, 7) == 0);
            #2;
            e = m_expect();
            total++;
            if (dut_out !== e) begin
                bad++;
                $display("FAIL random_out_c%0d: got %b want %b", c, dut_out, e);
            end
            model_clock();
            total++;
            if (stall_cnt !== 16'(m_stall)) begin
                bad++;
                $display("FAIL random_stall_cnt_c%0d: got %0d want %0d", c, stall_cnt, m_stall);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(1, 1, 1, 0, 0, 0, 4'b0001, 0);
        for (int c = 0; c < 70001; c++) model_clock();
        #2;
        total++;
        if (dut_out !== O_STALL) begin
            bad++;
            $display("FAIL sat_outputs: got %b want %b", dut_out, O_STALL);
        end
        total++;
        if (stall_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_stall_cnt: got %h want ffff", stall_cnt);
        end
        total++;
        if (16'(m_stall) !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_model_cnt: got %0d want 65535", m_stall);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        set_in(1, 2, 0, 0, 0, 0, 4'b0000, 1);
        model_clock();
        set_in(0, 0, 2, 0, 0, 0, 4'b0001, 0);
        #2;
        total++;
        if (dut_out !== O_FLUSH) begin
            bad++;
            $display("FAIL mid_flush_pre: got %b want %b", dut_out, O_FLUSH);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (dut_out !== O_RUN) begin
            bad++;
            $display("FAIL mid_flush_reset_out: got %b want %b", dut_out, O_RUN);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #2;
        total++;
        if (dut_out !== O_RUN) begin
            bad++;
            $display("FAIL mid_flush_scoreboard_clear: got %b want %b", dut_out, O_RUN);
        end
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL mid_flush_stall_cnt: got %0d want 0", stall_cnt);
        end
        model_clock();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_invalid_src();
        test_branch_in_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_flush();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
